ad7873_port_arbiter: RTL
========================

Name: ad7873_port_arbiter

Overview:
Serial-port master and two-requester arbiter for the AD7873 touch ADC. Requester 0 is the touchpad scan/averaging engine and requester 1 is the aux-channel sampler (battery or temperature). Each requester submits an 8-bit control byte and receives a 12-bit conversion result. The block owns touch_clk, touch_csb and data_out, and grants the single ADC frame to one requester at a time using round-robin.

Parameters:
CLK_DIV, 50, number of cclk cycles per touch_clk half-period; legal range 2..255.
FRAME_LEN, 24, touch_clk periods per frame (8 command + 16 read); fixed, not for override.

Ports:
cclk  in  1  system clock; all logic on its rising edge
rstb  in  1  reset, synchronous, active-low
req0  in  1  requester 0 transaction request; level held until ack0
cmd0  in  8  requester 0 control byte; sampled on the grant edge
ack0  out  1  one-cycle pulse; result0 valid in the same cycle
result0  out  12  requester 0 conversion result; holds until its next ack
err0  out  1  pulse with ack0 when a busy-check failure occurs (see Optional Feature)
req1, cmd1, ack1, result1, err1  same widths and semantics as above, for requester 1
touch_clk  out  1  ADC serial clock
touch_csb  out  1  ADC chip select, active-low
data_out  out  1  serial data to ADC din
data_in  in  1  serial data from ADC dout
touch_busy  in  1  ADC busy
grant_id  out  1  index of the owner of the current or most recent frame

Behaviour:
- Reset values (rstb=0 at a cclk edge): touch_csb=1, touch_clk=0, data_out=0, ack*=0, err*=0, result*=0, grant_id=0, last_grant=1 (so requester 0 wins the first tie), state=IDLE. Reset mid-frame aborts the frame at that edge; no ack is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If any req is high at edge N, grant at edge N. With a single requester, that requester wins. With both high, the requester != last_grant wins.
  - Latch the winner's cmd with bit 7 forced to 1 (start bit). Set grant_id and last_grant.
  - touch_csb goes low at N; data_out = cmd bit 7 at N.
- SHIFT: half-period counter runs 0..CLK_DIV-1; touch_clk toggles at each wrap.
  - First rising edge of touch_clk occurs at N+CLK_DIV.
  - data_out changes only on touch_clk falling edges, MSB first. After 8 bits have been sent, data_out=0.
  - data_in is sampled on rising edges 10..21 (1-based): rising edge 10 gives result bit 11, and rising edge 21 gives bit 0.
  - The 24th falling edge occurs at N+48*CLK_DIV. At that edge: touch_csb=1, touch_clk=0, go to DONE.
- DONE: hold for CLK_DIV cycles (csb-high gap). On the last cycle, pulse the owner's ack and update its result. The other requester's outputs do not change. Return to IDLE, so ack occurs at N+49*CLK_DIV. A request still high in IDLE one cycle later starts a new arbitration.
- A requester must drop req in the cycle after ack or it is treated as a new request. req deasserted mid-frame is ignored: the frame completes and ack is still issued.
- cmd changes after grant do not affect the frame in progress.
- Never more than one ack per cycle. touch_csb is never low outside SHIFT.

Optional Feature:
Macro AD7873_BUSY_CHECK_EN.
- Defined: touch_busy is sampled on rising edge 9. If it is 0, the frame still completes, but the result is forced to 12'hFFF and err<owner> pulses together with ack.
- Undefined: touch_busy is unused, and err0/err1 are tied to 0.

Test Plan:
- Reset, CLK_DIV=2; req0=1, cmd0=8'h93 at edge N.
  - touch_csb low at N, first touch_clk rise at N+2, ack0 at N+98.
  - Captured din serial stream = 1001_0011 followed by 16 zeros.
- ADC model returns 12'hA5C; req1 alone → result1=12'hA5C on ack1; result0 unchanged.
- req0 and req1 high in the same cycle from reset, both held → grants in order 0,1,0,1 (check grant_id per frame); exactly one ack per frame.
- rstb=0 at frame half-period 30 → next edge touch_csb=1, touch_clk=0, no ack; after release, a new req0 runs a full clean frame.
- cmd0=8'h13 (start bit clear) → shifted byte is 8'h93.
- With AD7873_BUSY_CHECK_EN defined and touch_busy held at 0 → result0=12'hFFF, err0 pulses coincident with ack0. Without the macro, err0 stays 0.

Source files
------------

// File: rtl/ad7873_port_arbiter.sv
// ad7873_port_arbiter
// Serial-port master for the AD7873 touch ADC, shared between two requesters
// (0: touchpad scan engine, 1: aux-channel sampler) with round-robin
// arbitration. One frame = 24 touch_clk periods: 8 command bits out, then a
// 16-clock read window of which rising edges 10..21 carry the 12-bit result.
//
// Optional build macro: AD7873_BUSY_CHECK_EN
//   defined   : touch_busy is sampled on touch_clk rising edge 9; a low value
//               forces the result to 12'hFFF and pulses err<owner> with ack.
//   undefined : touch_busy is ignored and err0/err1 are constant 0.
//
// Requester handshake: a requester raises req and holds it until it sees its
// one-cycle ack; result is valid in the ack cycle and holds until that
// requester's next ack. req must drop in the cycle after ack, otherwise it is
// taken as a fresh request. cmd is captured on the grant edge only.

module ad7873_port_arbiter #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic        cclk,
    input  logic        rstb,
    input  logic        req0,
    input  logic [7:0]  cmd0,
    output logic        ack0,
    output logic [11:0] result0,
    output logic        err0,
    input  logic        req1,
    input  logic [7:0]  cmd1,
    output logic        ack1,
    output logic [11:0] result1,
    output logic        err1,
    output logic        touch_clk,
    output logic        touch_csb,
    output logic        data_out,
    input  logic        data_in,
    input  logic        touch_busy,
    output logic        grant_id,
    output logic [1:0]  dbg_state
);

    // Frame geometry (fixed by the ADC protocol, not meant for override).
    localparam int unsigned FRAME_LEN       = 24;
    localparam int unsigned EDGES_PER_FRAME = 2 * FRAME_LEN;

    // touch_clk edge bookkeeping: edge_cnt_q counts toggles already made in
    // the frame, so rising edge r (1-based) happens when edge_cnt_q == 2*(r-1).
    localparam logic [5:0] LAST_EDGE      = 6'(EDGES_PER_FRAME - 1);
    localparam logic [5:0] BUSY_EDGE      = 6'(2 * (9 - 1));
    localparam logic [5:0] RX_FIRST_EDGE  = 6'(2 * (10 - 1));
    localparam logic [5:0] RX_LAST_EDGE   = 6'(2 * (21 - 1));

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic [7:0]  div_cnt_q,  div_cnt_d;
    logic [5:0]  edge_cnt_q, edge_cnt_d;
    logic        sclk_q,     sclk_d;
    logic        csb_q,      csb_d;
    logic        dout_q,     dout_d;
    logic [7:0]  shreg_q,    shreg_d;
    logic [11:0] rx_q,       rx_d;
    logic        owner_q,    owner_d;
    logic        last_q,     last_d;
    logic        ack0_q,     ack0_d;
    logic        ack1_q,     ack1_d;
    logic [11:0] res0_q,     res0_d;
    logic [11:0] res1_q,     res1_d;

    // Combinational helpers
    logic        tick;
    logic        win;
    logic [11:0] final_res;

`ifdef AD7873_BUSY_CHECK_EN
    logic        busy_ok_q,  busy_ok_d;
    logic        err0_q,     err0_d;
    logic        err1_q,     err1_d;
`else
    logic        unused_busy;
    assign unused_busy = touch_busy;
`endif

    // Arbitration, frame sequencing, serial shifting and result hand-off.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        csb_d      = csb_q;
        dout_d     = dout_q;
        shreg_d    = shreg_q;
        rx_d       = rx_q;
        owner_d    = owner_q;
        last_d     = last_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        res0_d     = res0_q;
        res1_d     = res1_q;
        win        = 1'b0;
        final_res  = rx_q;
`ifdef AD7873_BUSY_CHECK_EN
        busy_ok_d  = busy_ok_q;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        if (!busy_ok_q) begin
            final_res = 12'hFFF;
        end
`endif

        tick = (div_cnt_q == DIV_MAX);

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // Tie goes to whoever did not own the previous frame.
                    win        = (req0 && req1) ? ~last_q : req1;
                    owner_d    = win;
                    last_d     = win;
                    // Bit 7 is the AD7873 start bit; force it on.
                    shreg_d    = (win ? cmd1 : cmd0) | 8'h80;
                    dout_d     = 1'b1;
                    csb_d      = 1'b0;
                    sclk_d     = 1'b0;
                    div_cnt_d  = 8'd0;
                    edge_cnt_d = 6'd0;
                    rx_d       = 12'd0;
`ifdef AD7873_BUSY_CHECK_EN
                    busy_ok_d  = 1'b1;
`endif
                    state_d    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    div_cnt_d  = 8'd0;
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 6'd1;
                    if (!sclk_q) begin
                        // Rising edge: the ADC's dout is stable here.
                        if ((edge_cnt_q >= RX_FIRST_EDGE) && (edge_cnt_q <= RX_LAST_EDGE)) begin
                            rx_d = {rx_q[10:0], data_in};
                        end
`ifdef AD7873_BUSY_CHECK_EN
                        if (edge_cnt_q == BUSY_EDGE) begin
                            busy_ok_d = touch_busy;
                        end
`endif
                    end else begin
                        // Falling edge: present the next command bit; zeros
                        // shift in behind the byte so din idles low.
                        shreg_d = {shreg_q[6:0], 1'b0};
                        dout_d  = shreg_q[6];
                        if (edge_cnt_q == LAST_EDGE) begin
                            csb_d   = 1'b1;
                            sclk_d  = 1'b0;
                            dout_d  = 1'b0;
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                // csb-high gap; the hand-off happens on its final cycle.
                if (tick) begin
                    div_cnt_d = 8'd0;
                    state_d   = ST_IDLE;
                    if (owner_q) begin
                        ack1_d = 1'b1;
                        res1_d = final_res;
`ifdef AD7873_BUSY_CHECK_EN
                        err1_d = ~busy_ok_q;
`endif
                    end else begin
                        ack0_d = 1'b1;
                        res0_d = final_res;
`ifdef AD7873_BUSY_CHECK_EN
                        err0_d = ~busy_ok_q;
`endif
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                csb_d   = 1'b1;
                sclk_d  = 1'b0;
                dout_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset also aborts any frame in flight without an ack.
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= 8'd0;
            edge_cnt_q <= 6'd0;
            sclk_q     <= 1'b0;
            csb_q      <= 1'b1;
            dout_q     <= 1'b0;
            shreg_q    <= 8'd0;
            rx_q       <= 12'd0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            res0_q     <= 12'd0;
            res1_q     <= 12'd0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            csb_q      <= csb_d;
            dout_q     <= dout_d;
            shreg_q    <= shreg_d;
            rx_q       <= rx_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            res0_q     <= res0_d;
            res1_q     <= res1_d;
        end
    end

`ifdef AD7873_BUSY_CHECK_EN
    // Busy-check flag and error pulses.
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            busy_ok_q <= 1'b1;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            busy_ok_q <= busy_ok_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    assign err0 = err0_q;
    assign err1 = err1_q;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign result0   = res0_q;
    assign result1   = res1_q;
    assign touch_clk = sclk_q;
    assign touch_csb = csb_q;
    assign data_out  = dout_q;
    assign grant_id  = owner_q;
    assign dbg_state = state_q;

endmodule
